dm_arbiter: RTL

- Two-port arbiter and sequencer in front of the 128x32 data memory.
- Port 0 is the CPU MEM stage. Port 1 is a secondary master (program loader / debug).
- Grants at most one access per cycle and drives the memory's addr/rd/wr/wdata.
- Tracks each read's owner and returns the one-cycle-late read data to that port with a valid strobe.

---
 rtl/dm_arbiter_if.sv | 17 +
 rtl/dm_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// One requester port of the data-memory arbiter: request/write handshake toward
// the arbiter and the grant plus read-return path back to the requester.
interface dm_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the 128x32 data memory: grants one access per
// cycle, drives the memory bus and routes one-cycle-late read data to its owner.
module dm_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_arbiter_if.slave   p0,
    dm_arbiter_if.slave   p1,
    output logic [AW-1:0] dm_addr,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          last_gnt_q, last_gnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          rd_owner_v_q, rd_owner_v_d;
    logic          rd_owner_q, rd_owner_d;
    logic          gnt0, gnt1, pick1;

    // Grants are gated by rst_n so nothing reaches the memory while in reset.
    always_comb begin
        pick1 = 1'b0;
        if (FIXED_PRIO != 0) begin
            pick1 = (starve_cnt_q == STARVE_LIM);
        end else begin
            pick1 = ~last_gnt_q;
        end
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (p0.req && p1.req) begin
                gnt1 = pick1;
                gnt0 = ~pick1;
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
    end

    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_rd    = 1'b0;
        dm_wr    = 1'b0;
        if (gnt1) begin
            dm_addr  = p1.addr;
            dm_wdata = p1.wdata;
            dm_wr    = p1.wr;
            dm_rd    = ~p1.wr;
        end else if (gnt0) begin
            dm_addr  = p0.addr;
            dm_wdata = p0.wdata;
            dm_wr    = p0.wr;
            dm_rd    = ~p0.wr;
        end
    end

    // Owner is re-captured every cycle so back-to-back reads return in grant order.
    always_comb begin
        rd_owner_v_d = dm_rd;
        rd_owner_d   = gnt1;
        last_gnt_d   = last_gnt_q;
        if (gnt1) begin
            last_gnt_d = 1'b1;
        end else if (gnt0) begin
            last_gnt_d = 1'b0;
        end
        starve_cnt_d = starve_cnt_q;
        if (gnt1 || !p1.req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q   <= 1'b1;
            starve_cnt_q <= '0;
            rd_owner_v_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
            rd_owner_v_q <= rd_owner_v_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rd_owner_v_q & ~rd_owner_q;
    assign p1.rvalid = rd_owner_v_q & rd_owner_q;
    assign p0.rdata  = dm_rdata;
    assign p1.rdata  = dm_rdata;

endmodule
